conv3x3_mac: RTL and testbench

- Datapath stage directly downstream of the 3x3 kernel-window generator.
- Each valid 3x3 window carries 9 positions × 8 packed int8 channels (64-bit words).
- Block multiplies each window by a matching 3x3×8 weight tile and accumulates successive windows over the input-channel groups of one output pixel.
- Adds bias and emits one saturated 32-bit partial result per output pixel for the downstream requantiser.

---
 rtl/conv3x3_mac.sv | 147 ++++++++++++++
 tb/tb_conv3x3_mac.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_mac.sv
// rtl/conv3x3_mac.sv - 3x3x8 int8 window MAC with per-pixel channel-group accumulation
// Four-stage pipeline: products, per-position sums, window sum, saturating accumulate; then output register.
module conv3x3_mac #(
    parameter int LANES = 8,
    parameter int ACC_W = 32,
    parameter int GRP_W = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [GRP_W-1:0]                    cin_groups,
    input  logic                                frame_start,
    input  logic [2:0][2:0][LANES*8-1:0]        window,
    input  logic                                window_valid,
    input  logic [2:0][2:0][LANES*8-1:0]        weights,
    input  logic signed [ACC_W-1:0]             bias,
    output logic signed [ACC_W-1:0]             acc_out,
    output logic                                acc_valid,
    output logic                                sat_flag,
    output logic                                busy
);

    localparam int PW  = 16;
    localparam int S2W = PW + 3;
    localparam int S3W = S2W + 4;

    logic clr;
    assign clr = rst | frame_start;

    logic [GRP_W-1:0] cnt_q, cnt_d;
    logic             grp_first, grp_last;
    assign grp_first = (cnt_q == '0);
    assign grp_last  = (cnt_q == cin_groups - GRP_W'(1));
    assign cnt_d     = grp_last ? '0 : cnt_q + GRP_W'(1);

    logic [8:0][LANES-1:0][PW-1:0] prod_d, p1_q;
    logic                          v1_q, f1_q, l1_q;
    logic signed [ACC_W-1:0]       b1_q;

    logic [8:0][S2W-1:0]           s2_d, s2_q;
    logic                          v2_q, f2_q, l2_q;
    logic signed [ACC_W-1:0]       b2_q;

    logic [S3W-1:0]                s3_d, s3_q;
    logic                          v3_q, f3_q, l3_q;
    logic signed [ACC_W-1:0]       b3_q;

    logic signed [ACC_W-1:0]       acc_q, acc_d;
    logic                          sat_d;
    logic                          fin_q;

    // Sign-extended operands multiplied at 16 bits give the exact signed product.
    always_comb begin
        prod_d = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                for (int k = 0; k < LANES; k++) begin
                    prod_d[r*3+c][k] =
                        {{8{window[r][c][8*k+7]}},  window[r][c][8*k +: 8]} *
                        {{8{weights[r][c][8*k+7]}}, weights[r][c][8*k +: 8]};
                end
            end
        end
    end

    always_comb begin
        s2_d = '0;
        for (int p = 0; p < 9; p++) begin
            for (int k = 0; k < LANES; k++) begin
                s2_d[p] = s2_d[p] + {{(S2W-PW){p1_q[p][k][PW-1]}}, p1_q[p][k]};
            end
        end
    end

    always_comb begin
        s3_d = '0;
        for (int p = 0; p < 9; p++) begin
            s3_d = s3_d + {{(S3W-S2W){s2_q[p][S2W-1]}}, s2_q[p]};
        end
    end

    logic signed [ACC_W-1:0] op_a, op_b;
    logic        [ACC_W:0]   sum_w;

    // One guard bit detects overflow; the clamped value stays as the running operand.
    always_comb begin
        op_a  = f3_q ? b3_q : acc_q;
        op_b  = {{(ACC_W-S3W){s3_q[S3W-1]}}, s3_q};
        sum_w = {op_a[ACC_W-1], op_a} + {op_b[ACC_W-1], op_b};
        sat_d = (sum_w[ACC_W] != sum_w[ACC_W-1]);
        acc_d = sum_w[ACC_W-1:0];
        if (sat_d) begin
            acc_d = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q     <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            fin_q     <= 1'b0;
            acc_out   <= '0;
            acc_valid <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            v1_q <= window_valid;
            if (window_valid) begin
                cnt_q <= cnt_d;
                f1_q  <= grp_first;
                l1_q  <= grp_last;
                p1_q  <= prod_d;
                if (grp_first) begin
                    b1_q <= bias;
                end
            end

            v2_q <= v1_q;
            f2_q <= f1_q;
            l2_q <= l1_q;
            b2_q <= b1_q;
            s2_q <= s2_d;

            v3_q <= v2_q;
            f3_q <= f2_q;
            l3_q <= l2_q;
            b3_q <= b2_q;
            s3_q <= s3_d;

            fin_q <= v3_q & l3_q;
            if (v3_q) begin
                acc_q <= acc_d;
                if (sat_d) begin
                    sat_flag <= 1'b1;
                end
            end

            acc_valid <= fin_q;
            if (fin_q) begin
                acc_out <= acc_q;
            end
        end
    end

    assign busy = v1_q | v2_q | v3_q | (cnt_q != '0);

endmodule

// File: tb/tb_conv3x3_mac.sv
// tb/tb_conv3x3_mac.sv - scoreboard bench for conv3x3_mac
module tb_conv3x3_mac;

    typedef logic [2:0][2:0][63:0] win_t;
    typedef struct {
        logic [31:0] val;
        int          ed;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [15:0]        cin_groups = 16'd1;
    logic               frame_start = 1'b0;
    win_t               window = '0;
    logic               window_valid = 1'b0;
    win_t               weights = '0;
    logic signed [31:0] bias = '0;
    logic signed [31:0] acc_out;
    logic               acc_valid;
    logic               sat_flag;
    logic               busy;

    conv3x3_mac dut (
        .clk(clk), .rst(rst), .cin_groups(cin_groups), .frame_start(frame_start),
        .window(window), .window_valid(window_valid), .weights(weights), .bias(bias),
        .acc_out(acc_out), .acc_valid(acc_valid), .sat_flag(sat_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    int          pulses = 0;
    logic [31:0] last_val = '0;
    exp_t        q[$];

    int     m_cnt = 0;
    longint m_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Every pulse pops the scoreboard and is checked for value and latency.
    always @(negedge clk) begin
        if (!rst && acc_valid) begin
            pulses++;
            last_val = acc_out;
            n_total++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_pulse acc_out=%0d at edge %0d, none expected", acc_out, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (acc_out !== e.val)
                    $display("FAIL acc_value got %0d expected %0d", acc_out, $signed(e.val));
                else
                    n_pass++;
                n_total++;
                if (cyc !== e.ed)
                    $display("FAIL latency pulse at edge %0d expected %0d", cyc, e.ed);
                else
                    n_pass++;
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic win_t fill(input logic [7:0] v);
        win_t w;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                for (int k = 0; k < 8; k++)
                    w[r][c][8*k +: 8] = v;
        return w;
    endfunction

    function automatic win_t rnd_win();
        win_t w;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[r][c] = {$urandom(), $urandom()};
        return w;
    endfunction

    function automatic longint gsum(input win_t a, input win_t w);
        longint s = 0;
        logic signed [7:0] x, y;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                for (int k = 0; k < 8; k++) begin
                    x = a[r][c][8*k +: 8];
                    y = w[r][c][8*k +: 8];
                    s += longint'(x) * longint'(y);
                end
        return s;
    endfunction

    task automatic drive(input win_t a, input win_t w, input logic signed [31:0] b);
        longint t;
        bit     last;
        exp_t   e;
        @(negedge clk);
        window       = a;
        weights      = w;
        bias         = b;
        window_valid = 1'b1;
        t = (m_cnt == 0) ? longint'(b) + gsum(a, w) : m_acc + gsum(a, w);
        if (t > 64'sd2147483647) t = 64'sd2147483647;
        if (t < -64'sd2147483648) t = -64'sd2147483648;
        m_acc = t;
        last  = (m_cnt == int'(cin_groups) - 1);
        m_cnt = last ? 0 : m_cnt + 1;
        if (last) begin
            e.val = t[31:0];
            e.ed  = cyc + 1 + 4;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            window_valid = 1'b0;
            window       = rnd_win();
            weights      = rnd_win();
            bias         = $urandom();
        end
    endtask

    task automatic drain();
        int n = 0;
        idle(1);
        while ((q.size() != 0 || busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (q.size() != 0 || busy)
            $display("FAIL drain pending=%0d busy=%0b expected 0/0", q.size(), busy);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_total++; if (acc_out !== 32'sd0) $display("FAIL reset_acc_out got %0d expected 0", acc_out); else n_pass++;
        n_total++; if (acc_valid !== 1'b0) $display("FAIL reset_acc_valid got %0b expected 0", acc_valid); else n_pass++;
        n_total++; if (sat_flag !== 1'b0) $display("FAIL reset_sat_flag got %0b expected 0", sat_flag); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b expected 0", busy); else n_pass++;
    endtask

    task automatic test_single();
        int p0 = pulses;
        cin_groups = 16'd1;
        drive(fill(8'd1), fill(8'd1), 32'sd0);
        drain();
        n_total++; if (pulses - p0 !== 1) $display("FAIL single_pulses got %0d expected 1", pulses - p0); else n_pass++;
        n_total++; if (last_val !== 32'd72) $display("FAIL single_value got %0d expected 72", $signed(last_val)); else n_pass++;
        n_total++; if (sat_flag !== 1'b0) $display("FAIL single_sat got %0b expected 0", sat_flag); else n_pass++;
    endtask

    task automatic test_groups();
        int p0 = pulses;
        cin_groups = 16'd3;
        repeat (3) drive(fill(8'd2), fill(8'hFD), 32'sd100);
        drain();
        n_total++; if (pulses - p0 !== 1) $display("FAIL groups_pulses got %0d expected 1", pulses - p0); else n_pass++;
        n_total++; if (last_val !== -32'sd1196) $display("FAIL groups_value got %0d expected -1196", $signed(last_val)); else n_pass++;
    endtask

    task automatic test_gaps_back_to_back();
        int p0 = pulses;
        cin_groups = 16'd3;
        drive(fill(8'd2), fill(8'hFD), 32'sd100);
        idle(2);
        drive(fill(8'd2), fill(8'hFD), 32'sd100);
        idle(2);
        drive(fill(8'd2), fill(8'hFD), 32'sd100);
        repeat (3) drive(fill(8'd1), fill(8'd1), 32'sd0);
        drain();
        n_total++; if (pulses - p0 !== 2) $display("FAIL b2b_pulses got %0d expected 2", pulses - p0); else n_pass++;
        n_total++; if (last_val !== 32'd216) $display("FAIL b2b_value got %0d expected 216", $signed(last_val)); else n_pass++;
    endtask

    task automatic test_saturation();
        cin_groups = 16'd2000;
        repeat (2000) drive(fill(8'h80), fill(8'h80), 32'sd0);
        drain();
        n_total++; if (last_val !== 32'h7FFFFFFF) $display("FAIL sat_value got %h expected 7fffffff", last_val); else n_pass++;
        n_total++; if (sat_flag !== 1'b1) $display("FAIL sat_flag got %0b expected 1", sat_flag); else n_pass++;
        cin_groups = 16'd1;
        drive(fill(8'd1), fill(8'd1), 32'sd3);
        drain();
        n_total++; if (last_val !== 32'd75) $display("FAIL sat_after_value got %0d expected 75", $signed(last_val)); else n_pass++;
        n_total++; if (sat_flag !== 1'b1) $display("FAIL sat_sticky got %0b expected 1", sat_flag); else n_pass++;
    endtask

    task automatic test_frame_start();
        int p0 = pulses;
        cin_groups = 16'd4;
        repeat (2) drive(fill(8'd7), fill(8'd3), 32'sd9);
        @(negedge clk);
        window_valid = 1'b0;
        frame_start  = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        m_cnt = 0;
        n_total++; if (busy !== 1'b0) $display("FAIL fs_busy got %0b expected 0", busy); else n_pass++;
        n_total++; if (acc_out !== 32'sd0) $display("FAIL fs_acc_out got %0d expected 0", acc_out); else n_pass++;
        n_total++; if (sat_flag !== 1'b0) $display("FAIL fs_sat got %0b expected 0", sat_flag); else n_pass++;
        repeat (4) drive(fill(8'd1), fill(8'd1), 32'sd5);
        drain();
        n_total++; if (pulses - p0 !== 1) $display("FAIL fs_pulses got %0d expected 1", pulses - p0); else n_pass++;
        n_total++; if (last_val !== 32'd293) $display("FAIL fs_value got %0d expected 293", $signed(last_val)); else n_pass++;
    endtask

    task automatic test_random();
        int p0 = pulses;
        int sel;
        logic signed [31:0] b;
        for (int bt = 0; bt < 20; bt++) begin
            sel = $urandom_range(0, 2);
            cin_groups = (sel == 0) ? 16'd1 : (sel == 1) ? 16'd2 : 16'd7;
            for (int px = 0; px < 50; px++) begin
                case ($urandom_range(0, 7))
                    0:       b = 32'sh7FFF0000;
                    1:       b = -32'sh7FFF0000;
                    default: b = $urandom();
                endcase
                for (int g = 0; g < int'(cin_groups); g++) begin
                    if ($urandom_range(0, 9) < 3) idle($urandom_range(1, 3));
                    drive(rnd_win(), rnd_win(), b);
                end
            end
            drain();
        end
        n_total++; if (pulses - p0 !== 1000) $display("FAIL random_pulses got %0d expected 1000", pulses - p0); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_groups();
        test_gaps_back_to_back();
        test_saturation();
        test_frame_start();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
